writeback_arbiter: RTL and testbench

- Drives the register file's single write port (rd_address, write_data, write_enable) from two result sources.
- Source 1 is the single-cycle ALU path. Source 2 is the multi-cycle memory/load path, buffered in a small FIFO.
- Also keeps a per-register pending scoreboard for the decode stage, so hazards are stalled until the write lands.
- Sits between execute/memory and the register file.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 59 +++++
 rtl/writeback_arbiter.sv | 173 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]       data;
  } wb_result;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for memory results; head is read straight from the array.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter (ALU vs buffered loads) with a pending scoreboard.
// Optional macro WB_FORWARD_EN adds write-cycle forwarding outputs for decode.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int REG_ADDR_W   = WB_REG_ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_address,
  input  logic [REG_ADDR_W-1:0] rs2_address,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic [REG_ADDR_W-1:0] rd_address,
  output logic [XLEN-1:0]       write_data,
  output logic                  write_enable
`ifdef WB_FORWARD_EN
  ,
  output logic                  rs1_fwd_valid,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic                  rs2_fwd_valid,
  output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

  localparam int RES_W = REG_ADDR_W + XLEN;
  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [0:0] ST_NORMAL = NORMAL;
  localparam logic [0:0] ST_DRAIN  = DRAIN;

  logic [0:0]            state_reg, state_next;
  logic [CNT_W-1:0]      starve_cnt_reg, starve_cnt_next;
  logic                  write_enable_reg;
  logic [REG_ADDR_W-1:0] rd_address_reg;
  logic [XLEN-1:0]       write_data_reg;

  logic                  alu_xfer;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [RES_W-1:0]      fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  commit;
  logic [REG_ADDR_W-1:0] commit_rd;
  logic [XLEN-1:0]       commit_data;
  logic [NREGS-1:0]      pending;

  assign alu_ready = (state_reg == ST_NORMAL);
  assign mem_ready = !fifo_full;
  assign alu_xfer  = alu_valid && alu_ready;
  // x0 loads are accepted but never occupy a FIFO slot.
  assign fifo_push = mem_valid && mem_ready && (mem_rd != '0);
  assign {head_rd, head_data} = fifo_head;

  wb_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({mem_rd, mem_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    fifo_pop        = 1'b0;
    commit          = 1'b0;
    commit_rd       = alu_rd;
    commit_data     = alu_data;
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      ST_DRAIN: begin
        fifo_pop        = !fifo_empty;
        commit          = !fifo_empty;
        commit_rd       = head_rd;
        commit_data     = head_data;
        state_next      = ST_NORMAL;
        starve_cnt_next = '0;
      end
      default: begin
        if (alu_xfer) begin
          commit = (alu_rd != '0);
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          commit      = 1'b1;
          commit_rd   = head_rd;
          commit_data = head_data;
        end
        if (fifo_empty || fifo_pop) begin
          starve_cnt_next = '0;
        end else if (starve_cnt_reg == STARVE_LAST) begin
          state_next      = ST_DRAIN;
          starve_cnt_next = '0;
        end else begin
          starve_cnt_next = starve_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_NORMAL;
      starve_cnt_reg   <= '0;
      write_enable_reg <= 1'b0;
      rd_address_reg   <= '0;
      write_data_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      starve_cnt_reg   <= starve_cnt_next;
      write_enable_reg <= commit;
      if (commit) begin
        rd_address_reg <= commit_rd;
        write_data_reg <= commit_data;
      end
    end
  end

  assign write_enable = write_enable_reg;
  assign rd_address   = rd_address_reg;
  assign write_data   = write_data_reg;

  // Pending bits clear at the end of the write_enable cycle, so they stay visible
  // while the register file has not yet captured the value.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_pend
      logic pend_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          pend_reg <= 1'b0;
        end else if (issue_valid && (issue_rd != '0) && (issue_rd == REG_ADDR_W'(gi))) begin
          pend_reg <= 1'b1;
        end else if (write_enable_reg && (rd_address_reg == REG_ADDR_W'(gi))) begin
          pend_reg <= 1'b0;
        end
      end
      assign pending[gi] = pend_reg;
    end
  endgenerate

`ifdef WB_FORWARD_EN
  assign rs1_fwd_valid = write_enable_reg && (rd_address_reg == rs1_address) && (rs1_address != '0);
  assign rs2_fwd_valid = write_enable_reg && (rd_address_reg == rs2_address) && (rs2_address != '0);
  assign rs1_fwd_data  = write_data_reg;
  assign rs2_fwd_data  = write_data_reg;
  assign rs1_pending   = pending[rs1_address] && (rs1_address != '0) && !rs1_fwd_valid;
  assign rs2_pending   = pending[rs2_address] && (rs2_address != '0) && !rs2_fwd_valid;
`else
  assign rs1_pending   = pending[rs1_address] && (rs1_address != '0);
  assign rs2_pending   = pending[rs2_address] && (rs2_address != '0);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter with a queue-based reference model.
module tb_writeback_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int SLIM  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1_address, rs2_address, rd_address;
  logic [31:0] alu_data, mem_data, write_data;
  logic        rs1_pending, rs2_pending, write_enable;
`ifdef WB_FORWARD_EN
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(32), .REG_ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .rd_address(rd_address), .write_data(write_data), .write_enable(write_enable)
`ifdef WB_FORWARD_EN
    , .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, pending set, head wait time, expected write port.
  wb_result    q[$];
  bit [31:0]   pend;
  int          blocked;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          model_ok = 0;
  bit          alu_took, mem_took;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pending(input logic [4:0] a);
    bit p;
    p = (a != 0) && pend[a];
`ifdef WB_FORWARD_EN
    if (m_we && m_rd == a) p = 0;
`endif
    return p;
  endfunction

  // One clock cycle: check outputs, advance the model, cross the edge, land on negedge.
  task automatic step();
    bit forced, alu_x, mem_x, commit;
    wb_result c;
    #1;
    forced = (blocked >= SLIM);
    if (model_ok) begin
      chk("alu_ready", alu_ready, !forced);
      chk("mem_ready", mem_ready, q.size() < DEPTH);
      chk("write_enable", write_enable, m_we);
      chk("rd_address", rd_address, m_rd);
      chk("write_data", write_data, m_data);
      chk("rs1_pending", rs1_pending, exp_pending(rs1_address));
      chk("rs2_pending", rs2_pending, exp_pending(rs2_address));
    end
    if (reset) begin
      q.delete();
      pend = '0; blocked = 0; m_we = 0; m_rd = '0; m_data = '0;
      alu_took = 1; mem_took = 1;
    end else begin
      alu_x  = alu_valid && !forced;
      mem_x  = mem_valid && (q.size() < DEPTH);
      commit = 0;
      c      = '0;
      if (forced) begin
        if (q.size() > 0) begin c = q.pop_front(); commit = 1; end
        blocked = 0;
      end else if (alu_x) begin
        if (alu_rd != 0) begin c.rd = alu_rd; c.data = alu_data; commit = 1; end
        blocked = (q.size() > 0) ? blocked + 1 : 0;
      end else if (q.size() > 0) begin
        c = q.pop_front(); commit = 1; blocked = 0;
      end else begin
        blocked = 0;
      end
      if (m_we) pend[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
      if (commit) begin m_rd = c.rd; m_data = c.data; end
      m_we = commit;
      if (mem_x && mem_rd != 0) begin c.rd = mem_rd; c.data = mem_data; q.push_back(c); end
      alu_took = alu_x;
      mem_took = mem_x;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = '0; mem_rd = '0; issue_rd = '0; alu_data = '0; mem_data = '0;
  endtask

  initial begin
    int low_cnt;
    bit seen12;
    logic [4:0] wr_seq[$];
    logic [4:0] r;
    int first_wr;

    reset = 1; idle(); rs1_address = '0; rs2_address = '0;
    @(negedge clk);
    step(); step();
    reset = 0; model_ok = 1;
    #1;
    chk("rst_write_enable", write_enable, 1'b0);
    chk("rst_rd_address", rd_address, 5'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    for (int i = 0; i < 6; i++) step();

    // ALU write appears exactly one cycle after acceptance
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    chk("t1_we", write_enable, 1'b1);
    chk("t1_rd", rd_address, 5'd5);
    chk("t1_data", write_data, 32'hDEADBEEF);
    step();
    chk("t1_we_once", write_enable, 1'b0);

    // back-to-back loads retire in order, first one two cycles after push
    for (int i = 0; i < 4; i++) begin
      r = (i < 2) ? 5'(3 + i) : 5'(4 + i);
      mem_valid = 1; mem_rd = r; mem_data = 32'h1000 + 32'(i);
      step();
      if (write_enable) begin
        if (wr_seq.size() == 0) first_wr = i + 1;
        wr_seq.push_back(rd_address);
      end
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      step();
      if (write_enable) wr_seq.push_back(rd_address);
    end
    chk("t2_count", wr_seq.size(), 4);
    chk("t2_first_at", first_wr, 2);
    if (wr_seq.size() == 4) begin
      chk("t2_ord0", wr_seq[0], 5'd3);
      chk("t2_ord1", wr_seq[1], 5'd4);
      chk("t2_ord2", wr_seq[2], 5'd6);
      chk("t2_ord3", wr_seq[3], 5'd7);
    end

    // starvation: continuous ALU traffic forces one drain cycle
    mem_valid = 1; mem_rd = 5'd12; mem_data = 32'hC0FFEE;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    step();
    mem_valid = 0;
    low_cnt = 0; seen12 = 0;
    for (int i = 0; i < 14; i++) begin
      if (alu_took) begin alu_rd = (alu_rd == 5'd2) ? 5'd1 : 5'd2; alu_data = alu_data + 1; end
      step();
      if (!alu_ready) low_cnt++;
      if (write_enable && rd_address == 5'd12) seen12 = 1;
    end
    idle();
    chk("t3_ready_low_cycles", low_cnt, 1);
    chk("t3_fifo_written", seen12, 1'b1);
    step(); step();

    // scoreboard: pending from issue+1 through the write_enable cycle
    rs1_address = 5'd9;
    issue_valid = 1; issue_rd = 5'd9;
    step();
    issue_valid = 0;
    chk("t4_pending_set", rs1_pending, 1'b1);
    step(); step();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    idle();
    chk("t4_we", write_enable, 1'b1);
`ifdef WB_FORWARD_EN
    chk("t4_pending_fwd", rs1_pending, 1'b0);
    chk("t4_fwd_valid", rs1_fwd_valid, 1'b1);
    chk("t4_fwd_data", rs1_fwd_data, 32'h99);
`else
    chk("t4_pending_we", rs1_pending, 1'b1);
`endif
    step();
    chk("t4_pending_clr", rs1_pending, 1'b0);

    // x0 results are dropped
    alu_valid = 1; alu_rd = '0; alu_data = 32'hBAD;
    mem_valid = 1; mem_rd = '0; mem_data = 32'hBAD;
    issue_valid = 1; issue_rd = '0; rs1_address = '0;
    step();
    idle();
    chk("t5_we", write_enable, 1'b0);
    chk("t5_rs1_x0", rs1_pending, 1'b0);
    step();
    chk("t5_we2", write_enable, 1'b0);
    chk("t5_mem_ready", mem_ready, 1'b1);

    // fill the FIFO behind dropped ALU traffic, then reset with state outstanding
    alu_valid = 1; alu_rd = '0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; mem_rd = 5'(20 + i); mem_data = 32'h2000 + 32'(i);
      issue_valid = (i < 2); issue_rd = 5'(10 + i);
      step();
    end
    mem_valid = 0; issue_valid = 0;
    chk("t6_full", mem_ready, 1'b0);
    rs1_address = 5'd10; rs2_address = 5'd11;
    reset = 1; idle();
    step();
    reset = 0;
    chk("t6_we", write_enable, 1'b0);
    chk("t6_mem_ready", mem_ready, 1'b1);
    chk("t6_rs1_pend", rs1_pending, 1'b0);
    chk("t6_rs2_pend", rs2_pending, 1'b0);
    step(); step();

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 600; n++) begin
      if (alu_took || !alu_valid) begin
        alu_valid = ($urandom_range(0, 99) < 50);
        alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data  = $urandom;
      end
      if (mem_took || !mem_valid) begin
        mem_valid = ($urandom_range(0, 99) < 40);
        mem_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem_data  = $urandom;
      end
      issue_rd    = 5'($urandom_range(0, 31));
      issue_valid = ($urandom_range(0, 99) < 30) && !pend[issue_rd];
      rs1_address = 5'($urandom_range(0, 31));
      rs2_address = (m_we && $urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
